ptx_inst_encoder: RTL and testbench
===================================

# ptx_inst_encoder

Packs decoded PTX micro-op fields (functional-unit class, variant, register indices, immediate) back into 32-bit instruction words and streams them out through a buffered valid/ready interface. It is the encode-side counterpart of the SM's PTX decoder: the bit layout and opcode map here match the decoder's exactly. It sits between the instruction generator/patch logic and the SM instruction buffer, so decoded→re-encoded words round-trip losslessly. Illegal field combinations are rejected, flagged, and counted.

## Interface
- `DEPTH`, default 4: output FIFO entries; power of two, ≥2.
- `REG_WIDTH`, default 5: register index width. Fixed by the layout; must be 5.
- `clk` in 1: single clock. All state is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous; empties the FIFO.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: FIFO not full.
- `in_fu` in 3: functional-unit class; 0 ALU, 1 FPU, 2 LSU, 3 SFU, 4 BRA, 5–7 illegal.
- `in_variant` in 1: FPU 0 = fadd, 1 = fmul; LSU 0 = ld, 1 = st; ignored for all other classes.
- `in_vector` in 1: vector op.
- `in_use_imm` in 1: immediate form.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_imm` in 16: immediate.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts.
- `out_instr` out 32: encoded word at the FIFO head.
- `fifo_count` out $clog2(DEPTH+1): occupancy.
- `err_pulse` out 1: one-cycle pulse on an illegal input.
- `err_cnt` out 16: saturating illegal-input count.

## Operation
- Opcode map (all unlisted combinations are illegal):
  - ALU scalar: imm 0 → 0x00, imm 1 → 0x01.
  - FPU scalar: variant 0 → 0x02, variant 1 → 0x03.
  - LSU scalar: variant 0 → 0x04, variant 1 → 0x05.
  - BRA scalar → 0x06.
  - SFU scalar, no imm → 0x07.
  - ALU vector, no imm → 0x08.
  - FPU vector, variant 1, no imm → 0x09.
- Immediate rules:
  - `in_use_imm`=1 is legal only for ALU scalar, LSU and BRA.
  - FPU, SFU and any vector op with imm is illegal.
- Layout:
  - [31:26] opcode, [25:21] rd, [20:16] rs1.
  - Imm form: [15:0] = `in_imm`; `in_rs2` is ignored.
  - Reg form: [15:11] = `in_rs2`, [10:0] = 0.
- Encoding is combinational on the input fields. An accept is `in_valid && in_ready`.
- Legal accept: the word is pushed into the FIFO tail.
- Illegal accept:
  - The input is consumed, nothing is pushed.
  - `err_pulse` goes high the next cycle.
  - `err_cnt` increments and holds at 0xFFFF.
- Pop occurs when `out_valid && out_ready`. FIFO is circular; read/write pointers wrap modulo DEPTH.

## Timing
- Reset values: FIFO empty; `out_valid`=0, `out_instr`=0, `in_ready`=1, `fifo_count`=0, `err_pulse`=0, `err_cnt`=0. Asynchronous reset mid-stream discards all entries.
- Latency: a word accepted at edge N is presented with `out_valid`=1 after edge N (next cycle) when the FIFO was empty. Otherwise it follows FIFO order.
- `in_ready` = !full. It depends only on registered occupancy; there is no combinational path from `out_ready`. When full, no push occurs even if a pop happens in the same cycle.
- Simultaneous push and pop when not full or empty: `fifo_count` is unchanged and pointers advance.
- Pop when empty: impossible, because `out_valid`=0.
- `out_instr` holds stable while `out_valid && !out_ready`.
- `flush` takes priority over push and pop in the same cycle: the FIFO empties and `in_ready`=1 next cycle. An illegal input accepted in the flush cycle is still counted.

## Configuration
- `PTX_ENC_ERR_CNT_EN` defined: the 16-bit saturating `err_cnt` register is present.
- `PTX_ENC_ERR_CNT_EN` undefined: `err_cnt` is tied to 0 and no counter is synthesized. `err_pulse` and illegal-input dropping are unaffected.

## Test plan
- add rd=1 rs1=2 rs2=3 (fu 0, scalar, no imm) → `out_instr`=0x00221800 one cycle after accept.
- addi rd=4 rs1=5 imm=0x1234 → 0x04851234, with `in_rs2` ignored.
- vector fmul rd=rs1=rs2=31 (fu 1, variant 1, vector) → 0x27FFF800. The same fields with variant 0 → nothing pushed, `err_pulse`=1, `err_cnt`=1.
- Hold `out_ready`=0 and push DEPTH legal words:
  - `in_ready` falls after the 4th.
  - `fifo_count`=4 and the head is stable.
  - Release `out_ready` → words drain in order, one per cycle.
- Continuous push and pop with `out_ready`=1 for 2×DEPTH+3 words → no bubbles after the first, correct order across pointer wrap.
- With the FIFO holding 3 entries:
  - Assert `flush` → `fifo_count`=0 and `out_valid`=0 next cycle.
  - Assert `rst_n`=0 asynchronously mid-stream → all outputs are at reset values immediately.
  - Drive 70000 illegal inputs → `err_cnt` saturates at 0xFFFF (counter compiled in).

Source files
------------

// File: rtl/ptx_inst_encoder_if.sv
// Bundle for ptx_inst_encoder: decoded field inputs, buffered instruction output stream
// and illegal-input status. The master drives fields; the slave is the encoder.
interface ptx_inst_encoder_if #(
    parameter int DEPTH     = 4,
    parameter int REG_WIDTH = 5
);
    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    logic [2:0]                     in_fu;
    logic                           in_variant;
    logic                           in_vector;
    logic                           in_use_imm;
    logic [REG_WIDTH-1:0]           in_rd;
    logic [REG_WIDTH-1:0]           in_rs1;
    logic [REG_WIDTH-1:0]           in_rs2;
    logic [15:0]                    in_imm;
    logic                           out_valid;
    logic                           out_ready;
    logic [31:0]                    out_instr;
    logic [$clog2(DEPTH+1)-1:0]     fifo_count;
    logic                           err_pulse;
    logic [15:0]                    err_cnt;

    modport master (
        output flush, in_valid, in_fu, in_variant, in_vector, in_use_imm,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, fifo_count, err_pulse, err_cnt
    );

    modport slave (
        input  flush, in_valid, in_fu, in_variant, in_vector, in_use_imm,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, fifo_count, err_pulse, err_cnt
    );
endinterface

// File: rtl/ptx_inst_encoder.sv
// Re-encodes decoded PTX micro-op fields into 32-bit words and buffers them in a circular FIFO.
// Define PTX_ENC_ERR_CNT_EN to build the 16-bit saturating illegal-input counter (err_cnt).
module ptx_inst_encoder #(
    parameter int DEPTH     = 4,
    parameter int REG_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    ptx_inst_encoder_if.slave bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int OPND_W = 32 - 6 - 2 * REG_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [5:0]        w_opcode;
    logic              w_legal;
    logic [OPND_W-1:0] w_operand;
    logic [31:0]       w_word;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_illegal;

    logic [31:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_err_pulse;

    // Opcode map must stay identical to the SM decoder's so words round-trip losslessly.
    always_comb begin
        w_opcode = 6'h00;
        w_legal  = 1'b0;
        case (bus.in_fu)
            3'd0: begin
                if (!bus.in_vector) begin
                    w_legal  = 1'b1;
                    w_opcode = bus.in_use_imm ? 6'h01 : 6'h00;
                end else if (!bus.in_use_imm) begin
                    w_legal  = 1'b1;
                    w_opcode = 6'h08;
                end
            end
            3'd1: begin
                if (!bus.in_use_imm) begin
                    if (!bus.in_vector) begin
                        w_legal  = 1'b1;
                        w_opcode = bus.in_variant ? 6'h03 : 6'h02;
                    end else if (bus.in_variant) begin
                        w_legal  = 1'b1;
                        w_opcode = 6'h09;
                    end
                end
            end
            3'd2: begin
                if (!bus.in_vector) begin
                    w_legal  = 1'b1;
                    w_opcode = bus.in_variant ? 6'h05 : 6'h04;
                end
            end
            3'd3: begin
                if (!bus.in_vector && !bus.in_use_imm) begin
                    w_legal  = 1'b1;
                    w_opcode = 6'h07;
                end
            end
            3'd4: begin
                if (!bus.in_vector) begin
                    w_legal  = 1'b1;
                    w_opcode = 6'h06;
                end
            end
            default: begin
                w_legal  = 1'b0;
                w_opcode = 6'h00;
            end
        endcase
    end

    assign w_operand = bus.in_use_imm ? bus.in_imm : {bus.in_rs2, 11'd0};
    assign w_word    = {w_opcode, bus.in_rd, bus.in_rs1, w_operand};

    // in_ready depends only on registered occupancy, never on out_ready.
    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_illegal   = w_accept && !w_legal;
    assign w_push      = w_accept && w_legal && !bus.flush;
    assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // Flush outranks push and pop; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_illegal;
        end
    end

`ifdef PTX_ENC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 16'h0000;
        end else if (w_illegal && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = 16'h0000;
`endif

    // Head is forced to zero while empty so stale storage never leaks out.
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_instr  = w_out_valid ? r_mem[r_rptr] : 32'h0000_0000;
    assign bus.fifo_count = r_count;
    assign bus.err_pulse  = r_err_pulse;
endmodule

// File: tb/tb_ptx_inst_encoder.sv
// Randomized and directed bench for ptx_inst_encoder against a table-driven reference model.
module tb_ptx_inst_encoder;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   checkEn = 1'b0;

    ptx_inst_encoder_if #(.DEPTH(DEPTH), .REG_WIDTH(5)) bus ();

    ptx_inst_encoder #(.DEPTH(DEPTH), .REG_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Legal opcode table; 2 in the imm/variant columns means "either value".
    int tFu  [10] = '{0, 0, 1, 1, 2, 2, 4, 3, 0, 1};
    int tVec [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int tImm [10] = '{0, 1, 0, 0, 2, 2, 2, 0, 0, 0};
    int tVar [10] = '{2, 2, 0, 1, 0, 1, 2, 2, 2, 1};
    int tOpc [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

    logic [31:0] expQ [$];
    logic [15:0] expCnt   = 16'h0000;
    logic        expPulse = 1'b0;

    function automatic void refEncode(input int fu, input int vec, input int useImm,
                                      input int variant, input int rd, input int rs1,
                                      input int rs2, input int imm,
                                      output bit legal, output logic [31:0] word);
        longint v;
        legal = 1'b0;
        word  = 32'h0;
        for (int k = 0; k < 10; k++) begin
            if (tFu[k] == fu && tVec[k] == vec &&
                (tImm[k] == 2 || tImm[k] == useImm) &&
                (tVar[k] == 2 || tVar[k] == variant)) begin
                legal = 1'b1;
                v = longint'(tOpc[k]) * 64'd67108864 + longint'(rd) * 64'd2097152 +
                    longint'(rs1) * 64'd65536 + (useImm != 0 ? longint'(imm) : longint'(rs2) * 64'd2048);
                word = v[31:0];
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on each rising edge from the inputs the bench drove.
    always @(posedge clk) begin
        bit          legal;
        logic [31:0] w;
        bit          acc;
        bit          doPop;
        if (rst_n) begin
            refEncode(int'(bus.in_fu), int'(bus.in_vector), int'(bus.in_use_imm),
                      int'(bus.in_variant), int'(bus.in_rd), int'(bus.in_rs1),
                      int'(bus.in_rs2), int'(bus.in_imm), legal, w);
            acc      = bus.in_valid && (expQ.size() < DEPTH);
            expPulse = acc && !legal;
`ifdef PTX_ENC_ERR_CNT_EN
            if (acc && !legal && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
`endif
            if (bus.flush) begin
                expQ.delete();
            end else begin
                doPop = (expQ.size() > 0) && bus.out_ready;
                if (doPop) void'(expQ.pop_front());
                if (acc && legal) expQ.push_back(w);
            end
        end
    end

    always @(negedge rst_n) begin
        expQ.delete();
        expCnt   = 16'h0000;
        expPulse = 1'b0;
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("out_valid",  {31'd0, bus.out_valid}, {31'd0, expQ.size() != 0});
            checkOutput("out_instr",  bus.out_instr, expQ.size() != 0 ? expQ[0] : 32'h0);
            checkOutput("fifo_count", 32'(bus.fifo_count), 32'(expQ.size()));
            checkOutput("in_ready",   {31'd0, bus.in_ready}, {31'd0, expQ.size() < DEPTH});
            checkOutput("err_pulse",  {31'd0, bus.err_pulse}, {31'd0, expPulse});
            checkOutput("err_cnt",    {16'd0, bus.err_cnt}, {16'd0, expCnt});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int fu, input int vec, input int useImm, input int variant,
                                 input int rd, input int rs1, input int rs2, input int imm);
        bus.in_fu      = 3'(fu);
        bus.in_vector  = 1'(vec);
        bus.in_use_imm = 1'(useImm);
        bus.in_variant = 1'(variant);
        bus.in_rd      = 5'(rd);
        bus.in_rs1     = 5'(rs1);
        bus.in_rs2     = 5'(rs2);
        bus.in_imm     = 16'(imm);
    endtask

    task automatic pickLegal();
        int k;
        k = $urandom_range(0, 9);
        applyStimulus(tFu[k], tVec[k],
                      tImm[k] == 2 ? int'($urandom_range(0, 1)) : tImm[k],
                      tVar[k] == 2 ? int'($urandom_range(0, 1)) : tVar[k],
                      $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 65535));
    endtask

    task automatic currentWord(output logic [31:0] w);
        bit legal;
        refEncode(int'(bus.in_fu), int'(bus.in_vector), int'(bus.in_use_imm),
                  int'(bus.in_variant), int'(bus.in_rd), int'(bus.in_rs1),
                  int'(bus.in_rs2), int'(bus.in_imm), legal, w);
    endtask

    initial begin
        bit          legal;
        logic [31:0] w;
        logic [31:0] words [DEPTH];
        logic [15:0] cntAfterOne;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        refEncode(0, 0, 0, 0, 1, 2, 3, 0, legal, w);
        checkOutput("ref_add", w, 32'h00221800);
        refEncode(0, 0, 1, 0, 4, 5, 27, 'h1234, legal, w);
        checkOutput("ref_addi", w, 32'h04851234);
        refEncode(1, 1, 0, 1, 31, 31, 31, 0, legal, w);
        checkOutput("ref_vfmul", w, 32'h27FFF800);
        refEncode(1, 1, 0, 0, 31, 31, 31, 0, legal, w);
        checkOutput("ref_vfadd_illegal", {31'd0, legal}, 32'd0);

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        checkEn = 1'b1;

        checkOutput("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_in_ready",   {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("rst_out_instr",  bus.out_instr, 32'd0);

        applyStimulus(0, 0, 0, 0, 1, 2, 3, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checkOutput("add_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("add_word",  bus.out_instr, 32'h00221800);
        bus.out_ready = 1'b1;
        step();

        applyStimulus(0, 0, 1, 0, 4, 5, $urandom_range(0, 31), 'h1234);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checkOutput("addi_word", bus.out_instr, 32'h04851234);
        step();

        applyStimulus(1, 1, 0, 1, 31, 31, 31, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checkOutput("vfmul_word", bus.out_instr, 32'h27FFF800);
        step();

`ifdef PTX_ENC_ERR_CNT_EN
        cntAfterOne = 16'd1;
`else
        cntAfterOne = 16'd0;
`endif
        applyStimulus(1, 1, 0, 0, 31, 31, 31, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checkOutput("illegal_pulse", {31'd0, bus.err_pulse}, 32'd1);
        checkOutput("illegal_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("illegal_cnt",   {16'd0, bus.err_cnt}, {16'd0, cntAfterOne});
        step();
        checkOutput("pulse_clear", {31'd0, bus.err_pulse}, 32'd0);

        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pickLegal();
            currentWord(words[i]);
            bus.in_valid = 1'b1;
            step();
            checkOutput("fill_in_ready", {31'd0, bus.in_ready}, {31'd0, i < DEPTH - 1});
        end
        bus.in_valid = 1'b0;
        checkOutput("fill_count", 32'(bus.fifo_count), DEPTH);
        repeat (3) begin
            step();
            checkOutput("fill_head_stable", bus.out_instr, words[0]);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drain_order", bus.out_instr, words[i]);
            step();
        end
        checkOutput("drain_empty", {31'd0, bus.out_valid}, 32'd0);

        bus.in_valid = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            pickLegal();
            step();
            checkOutput("stream_no_bubble", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        checkOutput("stream_done", {31'd0, bus.out_valid}, 32'd0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            pickLegal();
            step();
        end
        applyStimulus(5, 0, 0, 0, 1, 1, 1, 0);
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("flush_err",   {31'd0, bus.err_pulse}, 32'd1);

        bus.in_valid = 1'b1;
        repeat (3) begin
            pickLegal();
            step();
        end
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("arst_instr", bus.out_instr, 32'd0);
        checkOutput("arst_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("arst_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("arst_pulse", {31'd0, bus.err_pulse}, 32'd0);
        checkOutput("arst_cnt",   {16'd0, bus.err_cnt}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                pickLegal();
            end else begin
                applyStimulus($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                              $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                              $urandom_range(0, 31), $urandom_range(0, 65535));
            end
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;

`ifdef PTX_ENC_ERR_CNT_EN
        bus.out_ready = 1'b1;
        step();
        applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        repeat (70000) step();
        bus.in_valid = 1'b0;
        step();
        checkOutput("err_cnt_saturated", {16'd0, bus.err_cnt}, 32'h0000FFFF);
`endif

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
